// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the SR flag sequencer.
// Holds the controller state encoding and the set/clear operation codes.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_flag_sequencer_if.sv
// Request/ack and flag-bank bundle for the SR flag sequencer.
// The master side is the requesters plus the bank; the slave side is the sequencer.
interface sr_flag_sequencer_if #(
  parameter int N_FLAGS = 8,
  parameter int IDX_W   = 3
);
  logic               req0;
  logic               op0;
  logic [IDX_W-1:0]   idx0;
  logic               ack0;
  logic               req1;
  logic               op1;
  logic [IDX_W-1:0]   idx1;
  logic               ack1;
  logic [N_FLAGS-1:0] flag_q;
  logic [N_FLAGS-1:0] sr_en;
  logic [N_FLAGS-1:0] sr_s;
  logic [N_FLAGS-1:0] sr_r;
  logic               err;
  logic               busy;

  modport master (
    output req0, op0, idx0, req1, op1, idx1, flag_q,
    input  ack0, ack1, sr_en, sr_s, sr_r, err, busy
  );

  modport slave (
    input  req0, op0, idx0, req1, op1, idx1, flag_q,
    output ack0, ack1, sr_en, sr_s, sr_r, err, busy
  );
endinterface

// File: rtl/sr_flag_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time
// is granted; with a single request that requester is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       last_grant_nxt
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    last_grant_nxt = (gnt == 2'b00) ? last_grant : gnt[1];
  end

endmodule

// File: rtl/sr_flag_sequencer.sv
// Shares an external bank of enable-gated SR flags between two requesters:
// grant, strobe one bit for one cycle, read it back, then ack with an error flag.
module sr_flag_sequencer
  import sr_seq_pkg::*;
#(
  parameter int N_FLAGS = 8,
  parameter int IDX_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  sr_flag_sequencer_if.slave  bus
);

  localparam int              PAD_W = 1 << IDX_W;
  localparam logic [IDX_W:0]  N_LIM = (IDX_W + 1)'(N_FLAGS);

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               who_q, who_d;
  logic               op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               bad_idx_q, bad_idx_d;
  logic [N_FLAGS-1:0] sr_en_q, sr_en_d;
  logic [N_FLAGS-1:0] sr_s_q, sr_s_d;
  logic [N_FLAGS-1:0] sr_r_q, sr_r_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [1:0]         gnt;
  logic               last_grant_nxt;
  logic               gnt_op;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_in_range;
  logic [PAD_W-1:0]   gnt_onehot;
  logic [N_FLAGS-1:0] gnt_mask;
  logic [PAD_W-1:0]   flag_pad;
  logic               mismatch;

  rr_arb2 u_arb (
    .req            ({bus.req1, bus.req0}),
    .last_grant     (last_grant_q),
    .enable         (state_q == ST_IDLE),
    .gnt            (gnt),
    .last_grant_nxt (last_grant_nxt)
  );

  // Index arithmetic is done in the power-of-two padded width so that an
  // out-of-range index simply produces an empty strobe mask.
  always_comb begin
    gnt_op       = gnt[1] ? bus.op1  : bus.op0;
    gnt_idx      = gnt[1] ? bus.idx1 : bus.idx0;
    gnt_in_range = ({1'b0, gnt_idx} < N_LIM);
    gnt_onehot   = PAD_W'(1) << gnt_idx;
    gnt_mask     = gnt_in_range ? N_FLAGS'(gnt_onehot) : '0;
    flag_pad     = PAD_W'(bus.flag_q);
    mismatch     = !bad_idx_q && (flag_pad[idx_q] != op_q);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_nxt;
    who_d        = who_q;
    op_d         = op_q;
    idx_d        = idx_q;
    bad_idx_d    = bad_idx_q;
    sr_en_d      = '0;
    sr_s_d       = '0;
    sr_r_d       = '0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          who_d     = gnt[1];
          op_d      = gnt_op;
          idx_d     = gnt_idx;
          bad_idx_d = !gnt_in_range;
          sr_en_d   = gnt_mask;
          sr_s_d    = (gnt_op == OP_SET) ? gnt_mask : '0;
          sr_r_d    = (gnt_op == OP_SET) ? '0 : gnt_mask;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      // The bank has taken the strobe by now, so flag_q reflects the result.
      ST_CHECK: begin
        ack0_d  = !who_q;
        ack1_d  = who_q;
        err_d   = bad_idx_q | mismatch;
        state_d = ST_ACK;
      end
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      who_q        <= 1'b0;
      op_q         <= 1'b0;
      idx_q        <= '0;
      bad_idx_q    <= 1'b0;
      sr_en_q      <= '0;
      sr_s_q       <= '0;
      sr_r_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      who_q        <= who_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      bad_idx_q    <= bad_idx_d;
      sr_en_q      <= sr_en_d;
      sr_s_q       <= sr_s_d;
      sr_r_q       <= sr_r_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sr_en = sr_en_q;
  assign bus.sr_s  = sr_s_q;
  assign bus.sr_r  = sr_r_q;
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/sr_flag_sequencer.md
Name: sr_flag_sequencer

Overview:
- Controller that shares an external bank of N enable-gated SR flag flip-flops between two requesters.
- Arbitrates set/clear requests round-robin and drives the bank's per-bit en/s/r strobes for exactly one cycle, never with s=r=1.
- Reads the flag back, checks it, and returns a one-cycle ack with an error flag.
- Sits between software-facing request logic and the flag register bank.

Parameters:
- N_FLAGS, 8, number of SR flag bits in the bank (2..32)
- IDX_W, 3, width of a flag index; must satisfy 2**IDX_W >= N_FLAGS

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req0  input  1  requester 0 request; held high until ack0
- op0  input  1  requester 0 operation: 1 = set, 0 = clear
- idx0  input  IDX_W  requester 0 flag index
- ack0  output  1  one-cycle completion pulse to requester 0
- req1  input  1  requester 1 request
- op1  input  1  requester 1 operation
- idx1  input  IDX_W  requester 1 flag index
- ack1  output  1  one-cycle completion pulse to requester 1
- flag_q  input  N_FLAGS  current q outputs of the SR flag bank
- sr_en  output  N_FLAGS  per-bit enable to the bank
- sr_s  output  N_FLAGS  per-bit set strobe
- sr_r  output  N_FLAGS  per-bit reset strobe
- err  output  1  valid only with ack0/ack1: 1 = bad index or readback mismatch
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- All outputs are registered.
- Reset (reset=0, async): sr_en/sr_s/sr_r=0, ack0=ack1=0, err=0, busy=0, FSM=IDLE, last_grant=1 so requester 0 wins the first tie.
- Reset mid-transaction: the in-flight operation is dropped and no ack is issued; strobes drop immediately.
- FSM states:
  - IDLE: if req0 or req1, grant and latch op/idx/requester id, then go to DRIVE.
    - Only one request: that one is granted.
    - Both requests: the requester not equal to last_grant is granted; last_grant updates on grant.
  - DRIVE (1 cycle): sr_en[idx]=1 plus sr_s[idx]=op and sr_r[idx]=~op; all other bits are 0.
    - If idx >= N_FLAGS: no strobe is driven and the bad-index flag is latched.
    - Go to CHECK.
  - CHECK (1 cycle): compare flag_q[idx] against op and latch the mismatch, then go to ACK.
  - ACK (1 cycle): ack of the granted requester=1 and err=bad_idx|mismatch; then return to IDLE.
- Latency: request sampled at edge k produces strobes in cycle k+1 and ack in cycle k+3. Throughput is one operation per 4 cycles; back-to-back grants are possible from the cycle after ACK.
- Invariants (the verifier asserts both):
  - sr_s & sr_r == 0 in every cycle.
  - At most one sr_en bit is high.
- Requests arriving while busy are not sampled; the requester keeps req high.
- Request withdrawn before ack: the latched operation still completes and the ack is still pulsed.
- Inputs are latched at grant, so changes on op/idx during service are ignored.
- Same index requested with opposite ops simultaneously: serialized by arbitration; the final flag value follows the later grant.
- Request already at target value (e.g. set an already-set flag): strobe still driven, err=0.

Decomposition:
- Package sr_seq_pkg: FSM state enum (IDLE, DRIVE, CHECK, ACK) and constants OP_SET=1'b1, OP_CLR=1'b0.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: gnt[1:0] one-hot and the next last_grant.
  - Used in IDLE only.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0, busy=0.
- req0=1, op0=1, idx0=5, bank initially 0 ->
  - sr_en=0x20, sr_s=0x20, sr_r=0 one cycle after the sampling edge.
  - ack0=1, err=0 at k+3.
  - flag_q[5]=1.
- req0 and req1 asserted in the same cycle: (op0=1, idx0=2) and (op1=0, idx1=2) ->
  - Requester 0 is served first (ack0 at k+3), requester 1 next (ack1 at k+7).
  - Final flag_q[2]=0; sr_s & sr_r is never nonzero.
- Both requesters hold req continuously for 4 transactions -> grants alternate 0,1,0,1 and each ack arrives 4 cycles apart.
- N_FLAGS=6 instance, req1 with idx1=7 -> sr_en stays 0 throughout, ack1=1 with err=1.
- Faults:
  - Bank model with bit 3 stuck at 0, set idx 3 -> ack with err=1.
  - reset pulsed low during DRIVE -> strobes clear asynchronously, no ack, and the FSM restarts in IDLE.
